mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
Upstream sequencer and result collector for the mac4 multiply-accumulate stage.
- Buffers operand pairs from a valid/ready source in a small FIFO.
- Clears the mac4 accumulator, then streams exactly `len` pairs into mac4 via a/b/en.
- Waits for the mac4 pipeline to drain, then presents the accumulated sum on a valid/ready result port.
- Single clock domain; mac4 sits between the mac_* outputs and the mac_out input.

Parameters:
- WIDTH, 16, accumulator width; each operand is WIDTH/2 bits.
- DEPTH, 4, operand FIFO entries (power of two, >=2).
- LEN_W, 8, width of the element-count field.
- DRAIN, 3, cycles waited after the last issued element before sampling mac_out.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept (= !full).
- in_a  in  WIDTH/2  operand a.
- in_b  in  WIDTH/2  operand b.
- start  in  1  begin dot product; sampled only in IDLE.
- len  in  LEN_W  element count, captured with start.
- busy  out  1  high in any state other than IDLE.
- mac_a  out  WIDTH/2  to mac4 a.
- mac_b  out  WIDTH/2  to mac4 b.
- mac_en  out  1  to mac4 en.
- mac_clr_n  out  1  registered, active-low; drives mac4 reset.
- mac_out  in  WIDTH  from mac4 out.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  WIDTH  dot-product result.

Behaviour:
Reset (async, reset=0):
- FIFO emptied; state IDLE; element and drain counters 0.
- mac_clr_n=0, res_valid=0, res_data=0, mac_en=0, mac_a=mac_b=0, busy=0, in_ready=0.
- First edge after release: mac_clr_n=1, in_ready=1.
- Reset mid-operation abandons the operation; no result is produced.

FIFO:
- Push when in_valid & in_ready. This is allowed in every state; pairs beyond `len` stay queued for the next operation.
- Pop when mac_en=1.
- Push and pop in the same cycle when not full: occupancy unchanged.
- When full, in_ready=0 with no same-cycle bypass.
- Pointers wrap modulo DEPTH.

State machine:
- IDLE: on start=1, capture len into remaining counter → CLEAR.
- CLEAR (1 cycle): mac_clr_n registered low for exactly this cycle. Next state is DONE if len==0 (skips streaming), else STREAM.
- STREAM:
  - mac_en = FIFO non-empty; mac_a/mac_b = FIFO head while mac_en=1, else 0.
  - An empty FIFO produces bubbles (mac_en=0); bubbles are legal and do not count as elements.
  - Each mac_en cycle decrements remaining.
  - The cycle issuing the final element → DRAIN with drain counter = DRAIN.
- DRAIN:
  - mac_en=0; drain counter decrements each cycle.
  - At 0, capture res_data <= mac_out, set res_valid=1 → RESULT.
  - Rationale: mac4 latches operands on the en edge, the product one edge later and the accumulator one edge after that, so 3 cycles covers it.
- DONE (len==0 path only): res_data <= mac_out (0 after clear), res_valid=1 → RESULT.
- RESULT: hold res_valid/res_data stable until res_ready=1; the handshake cycle clears res_valid → IDLE.

Other rules:
- start outside IDLE is ignored, not queued.
- Arithmetic is done by mac4, wrapping modulo 2^WIDTH; this block does no arithmetic on data.
- Latency with a pre-filled FIFO, len=N: start edge → CLEAR(1) → STREAM(N) → DRAIN(DRAIN) → res_valid. This gives res_valid N+DRAIN+2 cycles after start is sampled.

Test Plan:
- Preload (1,2),(3,4),(5,6), start len=3 → exactly 3 mac_en pulses, res_data=44, res_valid 8 cycles after start; busy low after handshake.
- start len=0 → mac_clr_n pulse, no mac_en, res_data=0.
- len=4 with in_valid fed every other cycle, values (2,3)×4 → mac_en bubbles match FIFO empty cycles, res_data=24.
- Hold res_ready=0 for 10 cycles → res_valid/res_data stable; new start ignored; after accept returns to IDLE; start pulsed in RESULT has no effect.
- Push 6 pairs with no start (DEPTH=4) → in_ready low after 4 pushes; the 2 extra pairs are held off at the source. Then len=2 → first two pairs consumed, remaining two stay queued.
- Assert reset during STREAM of len=5 → all outputs at reset values immediately, FIFO empty; a new len=1 operation with (255,255) returns 65025. Also run len=2 with (255,255)×2 → res_data wraps to 64514.

Source files
------------

// File: rtl/mac_dot_seq.sv
// Sequencer for the mac4 stage: queues operand pairs, clears the accumulator,
// streams `len` pairs into mac4, waits for its pipeline, then returns the sum.
module mac_dot_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LEN_W = 8,
    parameter int DRAIN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH/2-1:0] in_a,
    input  logic [WIDTH/2-1:0] in_b,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic [WIDTH/2-1:0] mac_a,
    output logic [WIDTH/2-1:0] mac_b,
    output logic               mac_en,
    output logic               mac_clr_n,
    input  logic [WIDTH-1:0]   mac_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [2:0]         state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid is never withdrawn before that edge.
    localparam int HW = WIDTH / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t           state, state_d;
    logic [HW-1:0]    mem_a [DEPTH];
    logic [HW-1:0]    mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             ready_en, full, empty, push, pop;
    logic [LEN_W-1:0] remaining;
    logic [DW-1:0]    drain_cnt;
    logic             last_elem, capture;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_en & ~full;
    assign push      = in_valid & in_ready;
    assign pop       = mac_en;
    assign last_elem = mac_en && (remaining == LEN_W'(1));
    assign capture   = ((state == S_DRAIN) && (drain_cnt == '0)) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = (remaining == '0) ? S_DONE : S_STREAM;
            S_STREAM: if (last_elem) state_d = S_DRAIN;
            S_DRAIN:  if (drain_cnt == '0) state_d = S_RESULT;
            S_DONE:   state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        mac_en    = (state == S_STREAM) && !empty;
        mac_a     = '0;
        mac_b     = '0;
        state_dbg = state;
        if (mac_en) begin
            mac_a = mem_a[rd_ptr];
            mac_b = mem_b[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            drain_cnt <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            mac_clr_n <= 1'b0;
        end else begin
            // clear is registered so mac4 sees a clean low for the whole CLEAR cycle
            mac_clr_n <= (state_d != S_CLEAR);
            if ((state == S_IDLE) && start) remaining <= len;
            else if (mac_en)                remaining <= remaining - LEN_W'(1);
            if (last_elem)                                     drain_cnt <= DW'(DRAIN);
            else if ((state == S_DRAIN) && (drain_cnt != '0))  drain_cnt <= drain_cnt - DW'(1);
            if (capture) begin
                res_data  <= mac_out;
                res_valid <= 1'b1;
            end else if ((state == S_RESULT) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq with a behavioural mac4 attached and a queue-based
// reference of the operand stream and expected dot products.
module tb_mac_dot_seq;
    localparam int WIDTH = 16;
    localparam int HW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [HW-1:0]    in_a, in_b;
    logic             start;
    logic [7:0]       len;
    logic             busy;
    logic [HW-1:0]    mac_a, mac_b;
    logic             mac_en, mac_clr_n;
    logic [WIDTH-1:0] mac_out;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    int en_cnt  = 0;
    int clr_cnt = 0;
    logic [15:0]      pair_q[$];
    logic [15:0]      issued_q[$];
    logic [WIDTH-1:0] exp_q[$];

    mac_dot_seq #(.WIDTH(16), .DEPTH(4), .LEN_W(8), .DRAIN(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .start(start), .len(len), .busy(busy),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr_n(mac_clr_n),
        .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // mac4: operands latched on en, product one edge later, accumulate one after
    logic [HW-1:0]    m_a, m_b;
    logic             m_v1, m_v2;
    logic [WIDTH-1:0] m_prod, m_acc;
    always @(posedge clk or negedge mac_clr_n) begin
        if (!mac_clr_n) begin
            m_a <= '0; m_b <= '0; m_v1 <= 1'b0; m_v2 <= 1'b0; m_prod <= '0; m_acc <= '0;
        end else begin
            m_v1 <= mac_en;
            if (mac_en) begin
                m_a <= mac_a;
                m_b <= mac_b;
            end
            m_prod <= WIDTH'(m_a) * WIDTH'(m_b);
            m_v2   <= m_v1;
            if (m_v2) m_acc <= m_acc + m_prod;
        end
    end
    assign mac_out = m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference queue: pairs enter on an accepted push, leave in order on mac_en
    always @(negedge clk) begin
        if (reset) begin
            if (!mac_clr_n) clr_cnt++;
            if (mac_en) begin
                check("en_with_data", 32'(pair_q.size() > 0), 1);
                if (pair_q.size() > 0) begin
                    check("mac_a_head", mac_a, pair_q[0][15:8]);
                    check("mac_b_head", mac_b, pair_q[0][7:0]);
                    issued_q.push_back(pair_q.pop_front());
                end
                en_cnt++;
            end else begin
                check("idle_operands", {mac_a, mac_b}, 0);
            end
            if (in_valid && in_ready) pair_q.push_back({in_a, in_b});
        end
    end

    task automatic push_pair(input logic [HW-1:0] a, input logic [HW-1:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 200; k++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        check("push_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input int n, input int hold, input int exp_lat, input int exp_res);
        int lat;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] exp_v;
        issued_q.delete();
        en_cnt  = 0;
        clr_cnt = 0;
        start = 1'b1;
        len   = n[7:0];
        tick();
        start = 1'b0;
        lat = 0;
        while (!res_valid && lat < 400) begin
            tick();
            lat++;
        end
        check("res_valid_rise", res_valid, 1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        sum = '0;
        foreach (issued_q[i]) sum = sum + WIDTH'(issued_q[i][15:8]) * WIDTH'(issued_q[i][7:0]);
        exp_q.push_back(sum);
        exp_v = exp_q.pop_front();
        check("en_count", en_cnt, n);
        check("clr_pulse", clr_cnt, 1);
        check("res_data", res_data, exp_v);
        if (exp_res >= 0) check("res_const", res_data, exp_res);
        for (int h = 0; h < hold; h++) begin
            if (h == hold / 2) begin
                start = 1'b1;
                len   = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp_v);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_cleared", res_valid, 0);
        check("idle_after", busy, 0);
        if (hold > 0) begin
            repeat (3) tick();
            check("start_ignored_busy", busy, 0);
            check("start_ignored_en", en_cnt, n);
        end
    endtask

    initial begin
        int acc;
        int n;
        logic ok;
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        start = 1'b0; len = '0; res_ready = 1'b0;
        repeat (2) tick();
        check("rst_clr_n", mac_clr_n, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_ab", {mac_a, mac_b}, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        check("rel_clr_n", mac_clr_n, 1);
        check("rel_in_ready", in_ready, 1);

        push_pair(8'd1, 8'd2);
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        run_op(3, 0, 8, 44);

        run_op(0, 0, 2, 0);

        fork
            run_op(4, 0, -1, 24);
            begin
                for (int i = 0; i < 4; i++) begin
                    push_pair(8'd2, 8'd3);
                    tick();
                end
            end
        join

        push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        run_op(2, 10, 7, -1);

        // Overfill: the source keeps offering pairs, only DEPTH are taken
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ok = in_ready;
            tick();
            if (ok) begin
                acc++;
                in_a = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
            end
        end
        check("full_in_ready", in_ready, 0);
        check("full_accepted", acc, 4);
        in_valid = 1'b0;
        run_op(2, 0, 7, -1);
        check("partial_in_ready", in_ready, 1);
        run_op(2, 0, 7, -1);

        push_pair(8'd9, 8'd9);
        push_pair(8'd7, 8'd7);
        push_pair(8'd5, 8'd5);
        start = 1'b1;
        len = 8'd5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_en", mac_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clr_n", mac_clr_n, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_res_valid", res_valid, 0);
        pair_q.delete();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        push_pair(8'd255, 8'd255);
        run_op(1, 0, 6, 65025);
        push_pair(8'd255, 8'd255);
        push_pair(8'd255, 8'd255);
        run_op(2, 0, 7, 64514);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            fork
                run_op(n, $urandom_range(0, 2), -1, -1);
                begin
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    end
                end
            join
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
